// File: rtl/sample_seq_pkg.sv
// Package: sample_seq_pkg
// Shared types and constants for the sample sequencer.
//   state_t            FSM state encoding for module_sample_sequencer
//   DEFAULT_PERIOD_CYC capture period at 10 MHz (2 s)
//   is_busy()          true for states in which the sequencer is running or paused
package sample_seq_pkg;

    localparam int unsigned DEFAULT_PERIOD_CYC = 20_000_000;
    localparam int unsigned DEFAULT_SETTLE_CYC = 2;

    typedef enum logic [2:0] {
        SEQ_IDLE    = 3'd0,
        SEQ_RUN     = 3'd1,
        SEQ_SETTLE  = 3'd2,
        SEQ_CAPTURE = 3'd3,
        SEQ_PAUSE   = 3'd4,
        SEQ_DONE    = 3'd5
    } state_t;

    function automatic logic is_busy(input state_t st);
        return (st == SEQ_RUN) || (st == SEQ_SETTLE) || (st == SEQ_CAPTURE) ||
               (st == SEQ_PAUSE);
    endfunction

endpackage

// File: rtl/module_period_counter.sv
// Module: module_period_counter
// Period counter for the sample sequencer. Counts 0..PERIOD_CYC-1 and flags the
// two points the FSM reacts to: the last RUN cycle and the last SETTLE cycle.
//   clk_i        system clock
//   rst_ni       synchronous reset, active-low
//   clr_i        load zero (wins over inc_i)
//   inc_i        advance by one; count holds when neither clr_i nor inc_i
//   at_settle_o  count == PERIOD_CYC-SETTLE_CYC-1 (next step enters SETTLE)
//   at_end_o     count == PERIOD_CYC-1 (next step is the capture)
module module_period_counter #(
    parameter int unsigned PERIOD_CYC = 20_000_000,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_settle_o,
    output logic at_end_o
);

    localparam int unsigned CW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam logic [CW-1:0] SETTLE_AT = CW'(PERIOD_CYC - SETTLE_CYC - 1);
    localparam logic [CW-1:0] END_AT    = CW'(PERIOD_CYC - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_settle_o = (count_q == SETTLE_AT);
    assign at_end_o    = (count_q == END_AT);

endmodule

// File: rtl/module_sample_sequencer.sv
// Module: module_sample_sequencer
// Sequences the random-display datapath (LFSR -> PIPO register -> 7-seg). Runs a
// periodic capture with start / stop / freeze / single-step control.
//   clk, rst       clock and synchronous active-low reset
//   i_start        pulse: begin periodic capture from IDLE or DONE
//   i_stop         pulse: abort to IDLE
//   i_freeze       level: hold the period and settle progress
//   i_step         pulse while frozen: one settle burst plus one capture
//   i_lfsr_done    LFSR has traversed its full sequence
//   o_lfsr_en      LFSR step enable
//   o_reg_we       PIPO write strobe, one cycle per capture
//   o_blank        no valid sample displayed yet
//   o_busy         RUN, SETTLE, CAPTURE or PAUSE
//   o_capt_cnt     captures since start, wrapping
module module_sample_sequencer
    import sample_seq_pkg::*;
#(
    parameter int unsigned PERIOD_CYC = DEFAULT_PERIOD_CYC,
    parameter int unsigned SETTLE_CYC = DEFAULT_SETTLE_CYC,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_freeze,
    input  logic             i_step,
    input  logic             i_lfsr_done,
    output logic             o_lfsr_en,
    output logic             o_reg_we,
    output logic             o_blank,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_capt_cnt
);

    localparam int unsigned STEP_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SETTLE_CYC);

    state_t            state_q, state_d;
    state_t            held_q, held_d;      // state to resume when PAUSE ends
    state_t            eff_state;
    logic              step_busy_q, step_busy_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic [CNT_W-1:0]  capt_q, capt_d;
    logic              blank_q, blank_d;
    logic              done_seen_q, done_seen_d;
    logic              lfsr_en_q, reg_we_q, busy_q;
    logic              step_en, step_we;
    logic              cnt_clr, cnt_inc;
    logic              at_settle, at_end;
    logic              done_hit;

    module_period_counter #(
        .PERIOD_CYC (PERIOD_CYC),
        .SETTLE_CYC (SETTLE_CYC)
    ) u_period (
        .clk_i       (clk),
        .rst_ni      (rst),
        .clr_i       (cnt_clr),
        .inc_i       (cnt_inc),
        .at_settle_o (at_settle),
        .at_end_o    (at_end)
    );

    // PAUSE is transparent: the held state decides how the counter advances.
    assign eff_state = (state_q == SEQ_PAUSE) ? held_q : state_q;
    assign done_hit  = done_seen_q | i_lfsr_done;

    always_comb begin
        state_d     = state_q;
        held_d      = held_q;
        step_busy_d = step_busy_q;
        step_cnt_d  = step_cnt_q;
        capt_d      = capt_q;
        blank_d     = blank_q;
        done_seen_d = done_hit;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        step_en     = 1'b0;
        step_we     = 1'b0;

        if (i_stop) begin
            state_d     = SEQ_IDLE;
            held_d      = SEQ_RUN;
            step_busy_d = 1'b0;
            done_seen_d = 1'b0;
            cnt_clr     = 1'b1;
        end else begin
            unique case (state_q)
                SEQ_IDLE, SEQ_DONE: begin
                    if (i_start) begin
                        state_d     = i_freeze ? SEQ_PAUSE : SEQ_RUN;
                        held_d      = SEQ_RUN;
                        capt_d      = '0;
                        done_seen_d = 1'b0;
                        cnt_clr     = 1'b1;
                    end
                end
                SEQ_CAPTURE: begin
                    // The strobe is already out; only the follow-on state is decided here.
                    done_seen_d = 1'b0;
                    if (done_hit) begin
                        state_d = SEQ_DONE;
                    end else if (i_freeze) begin
                        state_d = SEQ_PAUSE;
                        held_d  = SEQ_RUN;
                    end else begin
                        state_d = SEQ_RUN;
                        cnt_inc = 1'b1;
                    end
                end
                SEQ_RUN, SEQ_SETTLE, SEQ_PAUSE: begin
                    // A step burst in flight keeps the sequencer paused until it completes.
                    if (i_freeze || step_busy_q) begin
                        state_d = SEQ_PAUSE;
                        held_d  = eff_state;
                    end else if (eff_state == SEQ_SETTLE) begin
                        if (at_end) begin
                            state_d = SEQ_CAPTURE;
                            cnt_clr = 1'b1;
                        end else begin
                            state_d = SEQ_SETTLE;
                            cnt_inc = 1'b1;
                        end
                    end else begin
                        state_d = at_settle ? SEQ_SETTLE : SEQ_RUN;
                        cnt_inc = 1'b1;
                    end

                    if (state_q == SEQ_PAUSE) begin
                        if (step_busy_q) begin
                            step_en = (step_cnt_q < STEP_LAST);
                            step_we = (step_cnt_q == STEP_LAST);
                            if (step_we) begin
                                step_busy_d = 1'b0;
                            end else begin
                                step_cnt_d = step_cnt_q + STEP_W'(1);
                            end
                        end else if (i_freeze && i_step) begin
                            step_busy_d = 1'b1;
                            step_cnt_d  = '0;
                        end
                    end
                end
                default: begin
                    state_d = SEQ_IDLE;
                end
            endcase
        end

        if ((state_d == SEQ_CAPTURE) || step_we) begin
            capt_d  = capt_q + CNT_W'(1);
            blank_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= SEQ_IDLE;
            held_q      <= SEQ_RUN;
            step_busy_q <= 1'b0;
            step_cnt_q  <= '0;
            capt_q      <= '0;
            blank_q     <= 1'b1;
            done_seen_q <= 1'b0;
            lfsr_en_q   <= 1'b0;
            reg_we_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            held_q      <= held_d;
            step_busy_q <= step_busy_d;
            step_cnt_q  <= step_cnt_d;
            capt_q      <= capt_d;
            blank_q     <= blank_d;
            done_seen_q <= done_seen_d;
            lfsr_en_q   <= (state_d == SEQ_SETTLE) | step_en;
            reg_we_q    <= (state_d == SEQ_CAPTURE) | step_we;
            busy_q      <= is_busy(state_d);
        end
    end

    assign o_lfsr_en  = lfsr_en_q;
    assign o_reg_we   = reg_we_q;
    assign o_blank    = blank_q;
    assign o_busy     = busy_q;
    assign o_capt_cnt = capt_q;

endmodule

// File: tb/tb_module_sample_sequencer.sv
// Testbench: tb_module_sample_sequencer
// Directed vectors against hand-computed expectations with PERIOD_CYC=10,
// SETTLE_CYC=2, CNT_W=4. Cycle k counts posedges after the one sampling i_start.
module tb_module_sample_sequencer;

    localparam int unsigned PERIOD = 10;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned CW     = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start, i_stop, i_freeze, i_step, i_lfsr_done;
    logic          o_lfsr_en, o_reg_we, o_blank, o_busy;
    logic [CW-1:0] o_capt_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    module_sample_sequencer #(
        .PERIOD_CYC (PERIOD),
        .SETTLE_CYC (SETTLE),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .i_freeze    (i_freeze),
        .i_step      (i_step),
        .i_lfsr_done (i_lfsr_done),
        .o_lfsr_en   (o_lfsr_en),
        .o_reg_we    (o_reg_we),
        .o_blank     (o_blank),
        .o_busy      (o_busy),
        .o_capt_cnt  (o_capt_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic do_stop();
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        i_start = 1'b0; i_stop = 1'b0; i_freeze = 1'b0; i_step = 1'b0; i_lfsr_done = 1'b0;

        // Reset state
        repeat (3) tick();
        check_eq("rst blank", o_blank, 1);
        check_eq("rst busy", o_busy, 0);
        check_eq("rst capt", o_capt_cnt, 0);
        check_eq("rst we", o_reg_we, 0);
        check_eq("rst en", o_lfsr_en, 0);
        rst = 1'b1;
        tick();

        // Periodic run; a second i_start at cycle 15 must be ignored
        do_start();
        check_eq("run busy@0", o_busy, 1);
        check_eq("run capt@0", o_capt_cnt, 0);
        for (int k = 1; k <= 32; k++) begin
            i_start = (k == 15);
            tick();
            i_start = 1'b0;
            check_eq($sformatf("run en@%0d", k), o_lfsr_en, (k % 10 == 8) || (k % 10 == 9));
            check_eq($sformatf("run we@%0d", k), o_reg_we, (k % 10 == 0));
            if (k % 10 == 0) check_eq($sformatf("run capt@%0d", k), o_capt_cnt, k / 10);
            if (k == 9)  check_eq("run blank@9", o_blank, 1);
            if (k == 10) check_eq("run blank@10", o_blank, 0);
        end
        do_stop();
        check_eq("stop busy", o_busy, 0);
        check_eq("stop capt held", o_capt_cnt, 3);

        // Stop on the cycle a capture would fire
        do_start();
        check_eq("restart capt", o_capt_cnt, 0);
        for (int k = 1; k <= 20; k++) begin
            i_stop = (k == 20);
            tick();
            i_stop = 1'b0;
            if (k == 10) check_eq("abort we@10", o_reg_we, 1);
            if (k == 19) check_eq("abort en@19", o_lfsr_en, 1);
        end
        check_eq("abort we", o_reg_we, 0);
        check_eq("abort busy", o_busy, 0);
        check_eq("abort capt", o_capt_cnt, 1);
        check_eq("abort blank", o_blank, 0);
        check_eq("abort en", o_lfsr_en, 0);

        // Freeze 4..13 with steps at 6 (honoured), 8 (in flight) and 16 (not frozen)
        do_start();
        for (int k = 1; k <= 21; k++) begin
            i_freeze = (k >= 4) && (k <= 13);
            i_step   = (k == 6) || (k == 8) || (k == 16);
            tick();
            i_step = 1'b0;
            check_eq($sformatf("frz en@%0d", k), o_lfsr_en,
                     (k == 7) || (k == 8) || (k == 18) || (k == 19));
            check_eq($sformatf("frz we@%0d", k), o_reg_we, (k == 9) || (k == 20));
            if (k == 9)  check_eq("frz capt@9", o_capt_cnt, 1);
            if (k == 12) check_eq("frz busy@12", o_busy, 1);
            if (k == 20) check_eq("frz capt@20", o_capt_cnt, 2);
        end
        i_freeze = 1'b0;
        do_stop();

        // Capture counter wrap after 16 captures
        do_start();
        for (int k = 1; k <= 160; k++) begin
            tick();
            if (k % 10 == 0) begin
                check_eq($sformatf("wrap we@%0d", k), o_reg_we, 1);
                check_eq($sformatf("wrap capt@%0d", k), o_capt_cnt, (k / 10) % 16);
            end
        end
        do_stop();

        // LFSR done before capture 3 -> DONE after it
        do_start();
        for (int k = 1; k <= 50; k++) begin
            i_lfsr_done = (k == 25);
            tick();
            i_lfsr_done = 1'b0;
            if (k == 30) begin
                check_eq("done we@30", o_reg_we, 1);
                check_eq("done capt@30", o_capt_cnt, 3);
            end
            if (k == 31) check_eq("done busy@31", o_busy, 0);
            if (k > 30) begin
                check_eq($sformatf("done we@%0d", k), o_reg_we, 0);
                check_eq($sformatf("done en@%0d", k), o_lfsr_en, 0);
            end
        end
        check_eq("done capt held", o_capt_cnt, 3);
        check_eq("done blank", o_blank, 0);
        do_start();
        check_eq("from done busy", o_busy, 1);
        check_eq("from done capt", o_capt_cnt, 0);

        // Reset in the middle of SETTLE
        for (int k = 1; k <= 8; k++) tick();
        check_eq("pre-rst en@8", o_lfsr_en, 1);
        rst = 1'b0;
        tick();
        check_eq("midrst blank", o_blank, 1);
        check_eq("midrst busy", o_busy, 0);
        check_eq("midrst en", o_lfsr_en, 0);
        check_eq("midrst we", o_reg_we, 0);
        check_eq("midrst capt", o_capt_cnt, 0);
        rst = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
